// File: rtl/regfile_wb_arb_pkg.sv
// regfile_wb_arb_pkg: writeback entry type shared by the arbiter and its buffer
package regfile_wb_arb_pkg;
    import riscv_pkg::*;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
    localparam int ENTRY_W = $bits(wb_entry_t);
    localparam int NREG    = 1 << REG_ADDR_W;
endpackage

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core-wide widths
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
endpackage

// File: rtl/regfile_wb_arb_if.sv
// regfile_wb_arb_if: writeback/issue bus of the regfile write-port arbiter
// master: pipeline side (drives A/B requests, load issue, issue operands)
// slave : arbiter side (drives b_ready, stall, regfile write port, conflict_cnt)
interface regfile_wb_arb_if #(parameter int CNT_W = 16);
    import riscv_pkg::*;
    logic                  a_valid;
    logic [REG_ADDR_W-1:0] a_rd;
    logic [XLEN-1:0]       a_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [REG_ADDR_W-1:0] b_rd;
    logic [XLEN-1:0]       b_data;
    logic                  ld_issue;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd_chk;
    logic                  stall;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_a3;
    logic [XLEN-1:0]       rf_wd3;
    logic [CNT_W-1:0]      conflict_cnt;
    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
               ld_issue, ld_rd, rs1, rs2, rd_chk,
        input  b_ready, stall, rf_we, rf_a3, rf_wd3, conflict_cnt
    );
    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
               ld_issue, ld_rd, rs1, rs2, rd_chk,
        output b_ready, stall, rf_we, rf_a3, rf_wd3, conflict_cnt
    );
endinterface

// File: rtl/regfile_wb_arb_wb_fifo.sv
// wb_fifo: sync FIFO with show-ahead head for buffered load returns
// ports: clk, rst (async high), push/din, pop, dout (head), full, empty
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    // extra pointer bit distinguishes full from empty
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    always_ff @(posedge clk)
        if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: arbitrates ALU and buffered load writebacks onto one regfile write port
// ports: clk, rst (async high), bus (slave modport): A/B writeback requests,
// load-issue scoreboard with issue stall, regfile write port, conflict counter
module regfile_wb_arb
    import riscv_pkg::*;
    import regfile_wb_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input logic              clk,
    input logic              rst,
    regfile_wb_arb_if.slave  bus
);
    wb_entry_t             head;
    logic                  full, empty, push, sel_h;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic [NREG-1:0]       pending, set_m, clr_m;
    logic [CNT_W-1:0]      cnt;
    assign bus.b_ready      = !full && !rst;
    assign push             = bus.b_valid && bus.b_ready;
    // head is taken only when A is absent; rd==0 heads are popped and dropped
    assign sel_h            = !bus.a_valid && !empty;
    assign bus.stall        = pending[bus.rs1] | pending[bus.rs2] | pending[bus.rd_chk];
    assign bus.conflict_cnt = cnt;
    wb_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({bus.b_rd, bus.b_data}),
        .pop   (sel_h),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        sel_rd     = rst ? '0 : bus.a_valid ? bus.a_rd : sel_h ? head.rd : '0;
        sel_data   = rst ? '0 : bus.a_valid ? bus.a_data : sel_h ? head.data : '0;
        bus.rf_a3  = sel_rd;
        bus.rf_wd3 = sel_data;
        bus.rf_we  = sel_rd != '0;
        set_m      = '0;
        clr_m      = '0;
        if (bus.ld_issue) set_m[bus.ld_rd] = 1'b1;
        if (sel_h && bus.rf_we) clr_m[head.rd] = 1'b1;
        set_m[0]   = 1'b0;
    end
    // set is OR-ed after the clear so a same-cycle re-issue keeps the bit
    always_ff @(posedge clk or posedge rst)
        if (rst) pending <= '0;
        else     pending <= (pending & ~clr_m) | set_m;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (bus.a_valid && !empty && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb_regfile_wb_arb: directed self-checking bench with a load-writeback scoreboard
module tb_regfile_wb_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arb_if #(.CNT_W(16)) bus();
    regfile_wb_arb #(.FIFO_DEPTH(2), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [36:0] b_q[$];
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_b(input logic [4:0] rd, input logic [31:0] d, input bit expect_wr);
        bus.b_valid = 1'b1;
        bus.b_rd    = rd;
        bus.b_data  = d;
        if (expect_wr) b_q.push_back({rd, d});
    endtask

    // A writes are checked against the live stimulus; load writes against the queue
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.a_valid) begin
                chk("a_we", 32'(bus.rf_we), 32'(bus.a_rd != 5'd0));
                if (bus.rf_we) begin
                    chk("a_wr_rd", 32'(bus.rf_a3), 32'(bus.a_rd));
                    chk("a_wr_data", bus.rf_wd3, bus.a_data);
                end
            end else if (bus.rf_we) begin
                if (b_q.size() == 0) chk("spurious_wr", 32'(bus.rf_we), 32'd0);
                else begin
                    logic [36:0] e;
                    e = b_q.pop_front();
                    chk("b_wr_rd", 32'(bus.rf_a3), 32'(e[36:32]));
                    chk("b_wr_data", bus.rf_wd3, e[31:0]);
                end
            end
        end
    end

    initial begin
        bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
        bus.ld_issue = 0; bus.ld_rd = 0;
        bus.rs1 = 0; bus.rs2 = 0; bus.rd_chk = 0;
        cyc();
        bus.a_valid = 1; bus.a_rd = 5'd3; bus.a_data = 32'h77; #1;
        chk("rst_we", 32'(bus.rf_we), 0);
        chk("rst_a3", 32'(bus.rf_a3), 0);
        chk("rst_wd3", bus.rf_wd3, 0);
        chk("rst_bready", 32'(bus.b_ready), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_cnt", 32'(bus.conflict_cnt), 0);
        cyc();
        bus.a_valid = 0; rst = 0; mon_en = 1; #1;
        chk("bready_after_rst", 32'(bus.b_ready), 1);

        // single load return, one-cycle latency
        push_b(5'd5, 32'hDEAD0001, 1); #1;
        chk("b_no_bypass", 32'(bus.rf_we), 0);
        cyc(); bus.b_valid = 0; #1;
        chk("b_lat_we", 32'(bus.rf_we), 1);
        chk("b_lat_a3", 32'(bus.rf_a3), 5);
        chk("b_lat_wd3", bus.rf_wd3, 32'hDEAD0001);
        cyc(); #1;
        chk("idle_we", 32'(bus.rf_we), 0);
        chk("idle_a3", 32'(bus.rf_a3), 0);

        // A held three cycles over a buffered load
        bus.a_valid = 1; bus.a_rd = 5'd3; bus.a_data = 32'h11;
        push_b(5'd7, 32'h22, 1); #1;
        chk("ovl_bready", 32'(bus.b_ready), 1);
        cyc(); bus.b_valid = 0; #1;
        chk("a_prio_a3", 32'(bus.rf_a3), 3);
        cyc();
        cyc(); bus.a_valid = 0; #1;
        chk("b_after_a_a3", 32'(bus.rf_a3), 7);
        chk("b_after_a_wd3", bus.rf_wd3, 32'h22);
        chk("cnt_overlap", 32'(bus.conflict_cnt), 2);
        cyc(); #1;
        chk("idle_we2", 32'(bus.rf_we), 0);

        // fill under continuous A; third push waits for a pop
        bus.a_valid = 1; bus.a_rd = 5'd4; bus.a_data = 32'h40;
        push_b(5'd10, 32'hA, 1); #1;
        chk("fill0_bready", 32'(bus.b_ready), 1);
        cyc(); push_b(5'd11, 32'hB, 1); #1;
        chk("fill1_bready", 32'(bus.b_ready), 1);
        cyc(); push_b(5'd12, 32'hC, 0); #1;
        chk("full_bready", 32'(bus.b_ready), 0);
        cyc(); #1;
        chk("full_hold", 32'(bus.b_ready), 0);
        cyc(); bus.a_valid = 0; #1;
        chk("full_during_pop", 32'(bus.b_ready), 0);
        chk("pop_a3", 32'(bus.rf_a3), 10);
        chk("cnt_fill", 32'(bus.conflict_cnt), 5);
        cyc(); b_q.push_back({5'd12, 32'hC}); #1;
        chk("bready_after_pop", 32'(bus.b_ready), 1);
        chk("pop2_a3", 32'(bus.rf_a3), 11);
        cyc(); bus.b_valid = 0; #1;
        chk("pop3_a3", 32'(bus.rf_a3), 12);
        cyc(); #1;
        chk("drained_we", 32'(bus.rf_we), 0);

        // scoreboard: pending set, stall, clear, set-wins re-issue
        bus.ld_issue = 1; bus.ld_rd = 5'd9; bus.rs1 = 5'd9; #1;
        chk("stall_same_cycle", 32'(bus.stall), 0);
        cyc(); bus.ld_issue = 0; push_b(5'd9, 32'h99, 1); #1;
        chk("stall_pending", 32'(bus.stall), 1);
        cyc(); bus.b_valid = 0; #1;
        chk("stall_during_wr", 32'(bus.stall), 1);
        chk("ld9_a3", 32'(bus.rf_a3), 9);
        cyc(); #1;
        chk("stall_cleared", 32'(bus.stall), 0);
        bus.ld_issue = 1;
        cyc(); bus.ld_issue = 0; push_b(5'd9, 32'h98, 1); #1;
        chk("stall_reissue", 32'(bus.stall), 1);
        cyc(); bus.b_valid = 0; bus.ld_issue = 1; #1;
        chk("reissue_wr_a3", 32'(bus.rf_a3), 9);
        cyc(); bus.ld_issue = 0; #1;
        chk("set_wins", 32'(bus.stall), 1);
        push_b(5'd9, 32'h97, 1);
        cyc(); bus.b_valid = 0;
        cyc(); #1;
        chk("stall_final_clear", 32'(bus.stall), 0);
        bus.rs1 = 0;

        // register 0 handling
        push_b(5'd0, 32'h55, 0);
        cyc(); bus.b_valid = 0; #1;
        chk("b_rd0_we", 32'(bus.rf_we), 0);
        cyc(); push_b(5'd6, 32'h66, 1);
        cyc(); bus.b_valid = 0; #1;
        chk("after_drop_a3", 32'(bus.rf_a3), 6);
        cyc(); bus.a_valid = 1; bus.a_rd = 5'd0; bus.a_data = 32'h33; #1;
        chk("a_rd0_we", 32'(bus.rf_we), 0);
        cyc(); bus.a_valid = 0; bus.ld_issue = 1; bus.ld_rd = 5'd0;
        cyc(); bus.ld_issue = 0; #1;
        chk("rd0_no_stall", 32'(bus.stall), 0);

        // rs2 / rd_chk lookups
        bus.ld_issue = 1; bus.ld_rd = 5'd20;
        cyc(); bus.ld_issue = 0; bus.rd_chk = 5'd20; #1;
        chk("stall_rd_chk", 32'(bus.stall), 1);
        bus.rd_chk = 0; bus.rs2 = 5'd20; #1;
        chk("stall_rs2", 32'(bus.stall), 1);
        bus.rs2 = 5'd21; #1;
        chk("stall_other", 32'(bus.stall), 0);
        bus.rs2 = 0;

        // reset mid-operation with a full buffer and pending bits
        bus.a_valid = 1; bus.a_rd = 5'd1; bus.a_data = 32'h1;
        push_b(5'd13, 32'hD, 0);
        cyc(); push_b(5'd14, 32'hE, 0);
        cyc(); bus.b_valid = 0; bus.rd_chk = 5'd20; #1;
        chk("pre_rst_stall", 32'(bus.stall), 1);
        chk("pre_rst_full", 32'(bus.b_ready), 0);
        rst = 1; #1;
        chk("mid_rst_we", 32'(bus.rf_we), 0);
        chk("mid_rst_a3", 32'(bus.rf_a3), 0);
        chk("mid_rst_wd3", bus.rf_wd3, 0);
        chk("mid_rst_bready", 32'(bus.b_ready), 0);
        chk("mid_rst_stall", 32'(bus.stall), 0);
        chk("mid_rst_cnt", 32'(bus.conflict_cnt), 0);
        cyc(); cyc();
        rst = 0; bus.a_valid = 0; #1;
        chk("post_rst_bready", 32'(bus.b_ready), 1);
        chk("post_rst_stall", 32'(bus.stall), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("post_rst_no_wr", 32'(bus.rf_we), 0);
        end
        bus.rd_chk = 0;
        cyc();
        chk("b_q_empty", 32'(b_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, depth of the load-return buffer (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the conflict counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port a_valid  in  1  ALU writeback request; always accepted.
REQ-007 SHALL have port a_rd  in  5  ALU destination register.
REQ-008 SHALL have port a_data  in  32  ALU writeback data.
REQ-009 SHALL have port b_valid  in  1  load-return request.
REQ-010 SHALL have port b_ready  out  1  load-return accept.
REQ-011 SHALL have port b_rd  in  5  load destination register.
REQ-012 SHALL have port b_data  in  32  load data.
REQ-013 SHALL have port ld_issue  in  1  load issued; marks ld_rd pending.
REQ-014 SHALL have port ld_rd  in  5  destination of the issued load.
REQ-015 SHALL have port rs1, rs2, rd_chk  in  5 each  source/destination registers of the instruction being issued.
REQ-016 SHALL have port stall  out  1  issue must hold.
REQ-017 SHALL have port rf_we  out  1  regfile write enable.
REQ-018 SHALL have port rf_a3  out  5  regfile write address.
REQ-019 SHALL have port rf_wd3  out  32  regfile write data.
REQ-020 SHALL have port conflict_cnt  out  CNT_W  saturating count of cycles in which the buffer head was blocked by A.

Function
REQ-021 SHALL accept B on a cycle where b_valid && b_ready, pushing {b_rd, b_data} into the FIFO; b_ready = !full && !rst.
REQ-022 SHALL drive the write port combinationally: if a_valid, select A; else if FIFO non-empty, select head; else idle.
REQ-023 SHALL assert rf_we only when the selected entry's rd != 0; rf_a3/rf_wd3 = selected rd/data, 0 when idle.
REQ-024 SHALL pop the FIFO head when it is selected, or immediately when head rd == 0 and A is not valid (dropped, no write).
REQ-025 SHALL give B minimum latency of one cycle: accepted at cycle N, written at N+1 at earliest; no same-cycle bypass of b_data.
REQ-026 SHALL hold the head unchanged while a_valid is high (A has fixed priority; no starvation guarantee).
REQ-027 SHALL not push when full: b_ready is low, so push and pop never coincide on a full FIFO; push and pop on a partial FIFO are both performed.
REQ-028 SHALL keep a 32-bit pending scoreboard: ld_issue with ld_rd != 0 sets pending[ld_rd]; a head write (pop with rf_we) clears pending[head rd].
REQ-029 SHALL let set win over clear when both target the same register in the same cycle.
REQ-030 SHALL ignore ld_issue with ld_rd == 0; pending[0] is constant 0.
REQ-031 SHALL compute stall combinationally = pending[rs1] | pending[rs2] | pending[rd_chk], using the registered scoreboard (no same-cycle clear visibility).
REQ-032 SHALL increment conflict_cnt once per cycle when a_valid and the FIFO is non-empty, saturating at all-ones.
REQ-033 SHALL not modify the scoreboard on A writes (A to a pending register is the issuer's responsibility, prevented by stall on rd_chk).

Reset
REQ-034 SHALL on rst: empty the FIFO, clear all pending bits, clear conflict_cnt; rf_we=0, rf_a3=0, rf_wd3=0, stall=0, b_ready=0.
REQ-035 SHALL discard buffered loads on reset mid-operation; b_ready=1 on the first cycle after rst deasserts.

Structure
REQ-036 SHALL take XLEN=32 and REG_ADDR_W=5 from the shared riscv_pkg; FIFO_DEPTH stays a local parameter.
REQ-037 SHALL implement the buffer as sub-module wb_fifo (sync FIFO, full/empty, show-ahead head).

Verification
REQ-038 SHALL test: B {rd=5, data=0xDEAD0001} with no A -> rf_we=1, rf_a3=5, rf_wd3=0xDEAD0001 the next cycle.
REQ-039 SHALL test: A {rd=3, 0x11} held 3 cycles while B {rd=7, 0x22} accepted -> rd=7 written in the cycle after A drops; conflict_cnt=2 or 3 per overlap.
REQ-040 SHALL test: 3 B pushes under continuous A -> b_ready=0 after 2 pushes, third held until one pop.
REQ-041 SHALL test: ld_issue rd=9, then rs1=9 -> stall=1 until the rd=9 write, stall=0 the next cycle; same-cycle re-issue of rd=9 keeps pending=1.
REQ-042 SHALL test: B rd=0 or A rd=0 -> rf_we=0, FIFO entry drained; ld_issue rd=0 never stalls.
REQ-043 SHALL test: rst asserted with 2 buffered entries and pending bits -> all outputs 0 immediately, no later writes.
